// File: rtl/divider_32bit_pkg.sv
// Shared definitions for the M-extension multiply/divide datapath.
// Holds the data width, divider FSM states and the funct3 op encodings.
package divider_32bit_pkg;

  localparam int XLEN = 32;
  localparam int STEP_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } div_state_t;

  // funct3 encodings, shared with multiplier_32bit
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/divider_32bit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and emit the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dq,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dq_next
);

  logic [WIDTH:0] rem_w;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    rem_w = {rem, dq[WIDTH-1]};
    diff  = rem_w - {1'b0, divisor};
    fits  = (rem_w >= {1'b0, divisor});
    // rem < divisor always holds, so the difference fits back in WIDTH bits
    rem_next = fits ? diff[WIDTH-1:0] : rem_w[WIDTH-1:0];
    dq_next  = {dq[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/divider_32bit.sv
// Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU with a
// start/busy/done handshake; one quotient bit per clock.
module divider_32bit
  import divider_32bit_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t        state_q, state_d;
  logic [STEP_W-1:0] step_q;
  logic [WIDTH-1:0]  rem_q, dq_q, dvs_q;
  logic              neg_q_q, neg_r_q;

  logic              accept;
  logic              div_zero, overflow, fast_path;
  logic              sgn_a, sgn_b;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH-1:0]  fast_q, fast_r;
  logic [WIDTH-1:0]  rem_next, dq_next;

  always_comb begin
    accept    = start && (state_q != ST_CALC);
    div_zero  = (divisor == '0);
    overflow  = is_signed && (dividend == MOST_NEG) && (divisor == '1);
    fast_path = div_zero || overflow;
    sgn_a     = is_signed && dividend[WIDTH-1];
    sgn_b     = is_signed && divisor[WIDTH-1];
    // most-negative wraps to itself, which is the correct unsigned magnitude
    mag_a     = sgn_a ? -dividend : dividend;
    mag_b     = sgn_b ? -divisor : divisor;
    fast_q    = div_zero ? '1 : dividend;
    fast_r    = div_zero ? dividend : '0;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dq       (dq_q),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .dq_next  (dq_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = fast_path ? ST_FINISH : ST_CALC;
      end
      ST_CALC: begin
        if (step_q == LAST_STEP) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (start) state_d = fast_path ? ST_FINISH : ST_CALC;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      rem_q     <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;

      if (state_q == ST_FINISH) begin
        quotient  <= neg_q_q ? -dq_q : dq_q;
        remainder <= neg_r_q ? -rem_q : rem_q;
        done      <= 1'b1;
        busy      <= 1'b0;
      end

      // A start in FINISH overrides the busy clear above (back-to-back issue)
      if (accept) begin
        busy   <= 1'b1;
        step_q <= '0;
        if (fast_path) begin
          dq_q    <= fast_q;
          rem_q   <= fast_r;
          neg_q_q <= 1'b0;
          neg_r_q <= 1'b0;
        end else begin
          dq_q    <= mag_a;
          rem_q   <= '0;
          dvs_q   <= mag_b;
          neg_q_q <= sgn_a ^ sgn_b;
          neg_r_q <= sgn_a;
        end
      end else if (state_q == ST_CALC) begin
        rem_q  <= rem_next;
        dq_q   <= dq_next;
        step_q <= step_q + 1'b1;
      end
    end
  end

endmodule
